prt_tx_drain: RTL and testbench

Initiator-side drain engine for the packet reference table (PRT). It takes slot IDs from the forwarding logic and opens a PRT read session for each one. It streams the stored frame bytes out on a valid/ready byte interface with an end-of-frame marker, then invalidates the slot so it can be reused. It sits between the PRT read/invalidate ports and the egress MAC/transmit path.

---
 rtl/prt_tx_drain.sv | 179 +++++++++++++++++
 tb/tb_prt_tx_drain.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prt_tx_drain.sv
// PRT initiator drain engine: opens a read session per slot, streams the
// frame out through an egress FIFO with last-byte marking, then invalidates.
module prt_tx_drain #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_SLOTS   = 2,
  parameter int FIFO_DEPTH  = 8,
  parameter int REQ_TIMEOUT = 64,
  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  tx_req_valid,
  input  logic [SW-1:0]         tx_req_slot,
  output logic                  tx_req_ready,
  output logic                  EN_start_reading_prt_entry,
  output logic [SW-1:0]         start_reading_prt_entry_slot,
  input  logic                  RDY_start_reading_prt_entry,
  output logic                  EN_read_prt_entry,
  input  logic [DATA_WIDTH:0]   read_prt_entry,
  input  logic                  RDY_read_prt_entry,
  output logic                  EN_invalidate_prt_entry,
  output logic [SW-1:0]         invalidate_prt_entry_slot,
  input  logic                  RDY_invalidate_prt_entry,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  output logic                  tx_last,
  input  logic                  tx_ready,
  output logic [15:0]           frames_sent,
  output logic                  drain_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] TWO = (AW+1)'(2);
  localparam logic [15:0] TO_LAST = 16'(REQ_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_DATA,
    INV_REQ
  } state_t;

  state_t                state;
  logic [SW-1:0]         cur_slot;
  logic [15:0]           timer;
  logic [15:0]           timer_inc;
  logic                  pend_vld;
  logic [DATA_WIDTH-1:0] pend_data;

  logic [DATA_WIDTH:0]   mem [FIFO_DEPTH];
  logic [DATA_WIDTH:0]   head;
  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [AW:0]           used;
  logic [AW:0]           free;
  logic                  empty;
  logic                  pop;
  logic                  push;
  logic                  push_last;
  logic                  beat;
  logic                  eof;

  assign used  = wr_ptr - rd_ptr;
  assign free  = DEPTH - used;
  assign empty = (wr_ptr == rd_ptr);
  assign pop   = !empty && tx_ready;
  assign head  = mem[rd_ptr[AW-1:0]];

  assign tx_valid = !empty;
  assign tx_data  = empty ? '0 : head[DATA_WIDTH-1:0];
  assign tx_last  = !empty && head[DATA_WIDTH];

  assign tx_req_ready                 = (state == IDLE);
  assign EN_start_reading_prt_entry   = (state == RD_REQ);
  assign start_reading_prt_entry_slot = cur_slot;
  assign EN_invalidate_prt_entry      = (state == INV_REQ);
  assign invalidate_prt_entry_slot    = cur_slot;

  // Two free entries: one for the held-back byte, one slack.
  assign EN_read_prt_entry = (state == RD_DATA) && (free >= TWO);
  assign beat = EN_read_prt_entry && RDY_read_prt_entry;
  assign eof  = read_prt_entry[DATA_WIDTH];

  assign timer_inc = (timer == 16'hFFFF) ? timer : timer + 16'd1;

  always_comb begin
    push      = 1'b0;
    push_last = 1'b0;
    if (state == RD_DATA && pend_vld) begin
      unique case (1'b1)
        beat: begin
          push      = 1'b1;
          push_last = eof;
        end
        !RDY_read_prt_entry: begin
          push      = 1'b1;
          push_last = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {push_last, pend_data};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= IDLE;
      cur_slot    <= '0;
      timer       <= '0;
      pend_vld    <= 1'b0;
      pend_data   <= '0;
      frames_sent <= '0;
      drain_err   <= 1'b0;
    end else begin
      drain_err <= 1'b0;
      unique case (state)
        IDLE: begin
          if (tx_req_valid) begin
            cur_slot <= tx_req_slot;
            timer    <= '0;
            state    <= RD_REQ;
          end
        end
        RD_REQ: begin
          if (RDY_start_reading_prt_entry) begin
            state <= RD_DATA;
          end else if (timer == TO_LAST) begin
            drain_err <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer_inc;
          end
        end
        RD_DATA: begin
          if (beat && !eof) begin
            pend_vld  <= 1'b1;
            pend_data <= read_prt_entry[DATA_WIDTH-1:0];
          end else if (beat) begin
            if (pend_vld) frames_sent <= frames_sent + 16'd1;
            pend_vld <= 1'b0;
            timer    <= '0;
            state    <= INV_REQ;
          end else if (!RDY_read_prt_entry) begin
            pend_vld  <= 1'b0;
            drain_err <= 1'b1;
            timer     <= '0;
            state     <= INV_REQ;
          end
        end
        INV_REQ: begin
          if (RDY_invalidate_prt_entry) begin
            state <= IDLE;
          end else if (timer == TO_LAST) begin
            drain_err <= 1'b1;
            state     <= IDLE;
          end else begin
            timer <= timer_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_prt_tx_drain.sv
// Bench for prt_tx_drain: directed and randomized drains checked against
// a frame-level model of the expected egress stream and PRT handshakes.
module tb_prt_tx_drain;

  localparam int DW = 8;
  localparam int FD = 8;
  localparam int TO = 64;
  localparam int SW = 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          tx_req_valid = 1'b0;
  logic [SW-1:0] tx_req_slot = '0;
  logic          tx_req_ready;
  logic          EN_start;
  logic [SW-1:0] start_slot;
  logic          RDY_start = 1'b0;
  logic          EN_read;
  logic [DW:0]   read_prt_entry = '0;
  logic          RDY_read = 1'b0;
  logic          EN_inv;
  logic [SW-1:0] inv_slot;
  logic          RDY_inv = 1'b0;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_last;
  logic          tx_ready = 1'b0;
  logic [15:0]   frames_sent;
  logic          drain_err;

  prt_tx_drain dut (
    .CLK                          (CLK),
    .RST_N                        (RST_N),
    .tx_req_valid                 (tx_req_valid),
    .tx_req_slot                  (tx_req_slot),
    .tx_req_ready                 (tx_req_ready),
    .EN_start_reading_prt_entry   (EN_start),
    .start_reading_prt_entry_slot (start_slot),
    .RDY_start_reading_prt_entry  (RDY_start),
    .EN_read_prt_entry            (EN_read),
    .read_prt_entry               (read_prt_entry),
    .RDY_read_prt_entry           (RDY_read),
    .EN_invalidate_prt_entry      (EN_inv),
    .invalidate_prt_entry_slot    (inv_slot),
    .RDY_invalidate_prt_entry     (RDY_inv),
    .tx_data                      (tx_data),
    .tx_valid                     (tx_valid),
    .tx_last                      (tx_last),
    .tx_ready                     (tx_ready),
    .frames_sent                  (frames_sent),
    .drain_err                    (drain_err)
  );

  always #5 CLK = ~CLK;

  int          checks = 0;
  int          failures = 0;
  logic [DW:0] exp_q[$];
  int          beats_in = 0;
  int          popped = 0;
  bit          pend = 1'b0;
  int          rdy_pct = 100;
  logic [15:0] exp_frames = '0;
  bit          prev_stall = 1'b0;
  logic [DW:0] prev_head = '0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic settle();
    tx_ready = ($urandom_range(99) < rdy_pct);
    #1;
  endtask

  task automatic finish_cycle();
    if (prev_stall) begin
      chk("hold_valid", tx_valid, 1);
      chk("hold_head", {tx_last, tx_data}, prev_head);
    end
    if (tx_valid && tx_ready) begin
      if (exp_q.size() == 0) chk("tx_extra", tx_valid, 0);
      else chk("tx_beat", {tx_last, tx_data}, exp_q.pop_front());
      popped++;
    end
    prev_stall = tx_valid && !tx_ready;
    prev_head  = {tx_last, tx_data};
    @(negedge CLK);
  endtask

  task automatic tick();
    settle();
    finish_cycle();
  endtask

  task automatic flush();
    rdy_pct = 100;
    for (int g = 0; g < 100 && exp_q.size() > 0; g++) tick();
    settle();
    chk("flush_empty", tx_valid, 0);
    finish_cycle();
  endtask

  task automatic drain(input logic [SW-1:0] slot, input int n,
                       input int trunc_k, input int sdel, input int idel,
                       input int base);
    logic [DW-1:0] b[$];
    bit trunc;
    bit done;
    int k;
    int idx;
    int occ;
    trunc = (trunc_k >= 0);
    k = trunc ? trunc_k : n;
    for (int i = 0; i < k; i++)
      b.push_back((base >= 0) ? DW'(base + i) : DW'($urandom));
    for (int i = 0; i < k; i++) exp_q.push_back({i == k - 1, b[i]});
    if (!trunc && n > 0) exp_frames++;

    tx_req_valid = 1'b1;
    tx_req_slot  = slot;
    settle();
    chk("req_ready", tx_req_ready, 1);
    finish_cycle();
    tx_req_valid = 1'b0;

    for (int c = 0; c < TO; c++) begin
      RDY_start = (c == sdel);
      settle();
      chk("en_start", EN_start, 1);
      chk("start_slot", start_slot, slot);
      finish_cycle();
      if (c == sdel) break;
    end
    RDY_start = 1'b0;

    idx = 0;
    done = 1'b0;
    for (int g = 0; g < 2000 && !done; g++) begin
      if (idx < k) begin
        RDY_read = 1'b1;
        read_prt_entry = {1'b0, b[idx]};
      end else begin
        RDY_read = !trunc;
        read_prt_entry = {!trunc, DW'($urandom)};
      end
      settle();
      occ = beats_in - popped;
      chk("en_read", EN_read, (FD - occ) >= 2);
      if (!RDY_read) begin
        done = 1'b1;
        if (pend) beats_in++;
        pend = 1'b0;
      end else if (EN_read) begin
        if (idx < k) begin
          if (pend) beats_in++;
          pend = 1'b1;
          idx++;
        end else begin
          done = 1'b1;
          if (pend) beats_in++;
          pend = 1'b0;
        end
      end
      finish_cycle();
    end
    if (!done) begin
      checks++;
      failures++;
      $error("FAIL rd_data_budget got=stuck exp=frame_end");
    end
    RDY_read = 1'b0;

    for (int c = 0; c < TO; c++) begin
      RDY_inv = (c == idel);
      settle();
      if (c == 0) begin
        chk("err_after_read", drain_err, trunc);
        chk("frames_sent", frames_sent, exp_frames);
      end
      chk("en_inv", EN_inv, 1);
      chk("inv_slot", inv_slot, slot);
      finish_cycle();
      if (c == idel) break;
    end
    RDY_inv = 1'b0;

    settle();
    chk("idle_ready", tx_req_ready, 1);
    chk("idle_no_inv", EN_inv, 0);
    chk("err_after_inv", drain_err, idel < 0);
    finish_cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge CLK);
    #1;
    chk("rst_req_ready", tx_req_ready, 1);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_en", {EN_start, EN_read, EN_inv}, 0);
    chk("rst_frames", frames_sent, 0);
    chk("rst_err", drain_err, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    tick();

    rdy_pct = 100;
    drain(1'b1, 3, -1, 2, 1, 'hA1);
    flush();
    chk("basic_frames", frames_sent, 1);

    rdy_pct = 20;
    drain(1'b0, 20, -1, 0, 0, 0);
    flush();

    drain(1'b1, 0, -1, 1, 2, -1);
    flush();
    chk("zero_len_frames", frames_sent, exp_frames);

    tx_req_valid = 1'b1;
    tx_req_slot  = 1'b0;
    tick();
    tx_req_valid = 1'b0;
    for (int c = 0; c < TO; c++) begin
      settle();
      chk("to_en_start", EN_start, 1);
      chk("to_no_err", drain_err, 0);
      finish_cycle();
    end
    settle();
    chk("to_err", drain_err, 1);
    chk("to_ready", tx_req_ready, 1);
    chk("to_no_inv", EN_inv, 0);
    chk("to_no_start", EN_start, 0);
    finish_cycle();
    settle();
    chk("to_err_pulse", drain_err, 0);
    finish_cycle();

    drain(1'b0, 0, 2, 1, 0, 'h10);
    flush();

    drain(1'b1, 4, -1, 0, -1, -1);
    flush();

    for (int it = 0; it < 30; it++) begin
      rdy_pct = $urandom_range(100, 20);
      drain(SW'($urandom), $urandom_range(20),
            ($urandom_range(4) == 0) ? $urandom_range(6) : -1,
            $urandom_range(5), $urandom_range(4), -1);
    end
    flush();
    chk("rand_frames", frames_sent, exp_frames);

    rdy_pct = 0;
    tx_req_valid = 1'b1;
    tx_req_slot  = 1'b1;
    tick();
    tx_req_valid = 1'b0;
    RDY_start = 1'b1;
    tick();
    RDY_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      RDY_read = 1'b1;
      read_prt_entry = {1'b0, DW'(8'h40 + i)};
      tick();
    end
    RST_N = 1'b0;
    #1;
    chk("mid_req_ready", tx_req_ready, 1);
    chk("mid_tx_valid", tx_valid, 0);
    chk("mid_tx_data", tx_data, 0);
    chk("mid_tx_last", tx_last, 0);
    chk("mid_en", {EN_start, EN_read, EN_inv}, 0);
    chk("mid_frames", frames_sent, 0);
    chk("mid_err", drain_err, 0);
    RDY_read = 1'b0;
    exp_q.delete();
    beats_in = 0;
    popped = 0;
    pend = 1'b0;
    exp_frames = '0;
    prev_stall = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    rdy_pct = 100;
    settle();
    chk("post_rst_empty", tx_valid, 0);
    chk("post_rst_ready", tx_req_ready, 1);
    finish_cycle();

    drain(1'b0, 2, -1, 0, 0, 'h55);
    flush();
    chk("post_rst_frames", frames_sent, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
